// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, decode handshake and redirect.
// master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_q;
    logic [7:0]  ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        output mem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        input  mem_q, ir_ready, br_taken, br_target
    );

    modport slave (
        input  mem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        output mem_q, ir_ready, br_taken, br_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one instruction byte per cycle into ir and
// offers it to decode over valid/ready; branches redirect, a halt byte stops fetch.
//
// state   | meaning
// RUN     | fetching whenever the instruction register has a load slot
// HALTED  | halt byte fetched; PC frozen until a taken branch
module instr_fetch_unit #(
    parameter logic [31:0]     RESET_PC    = 32'd0,
    parameter longint unsigned MEM_DEPTH   = 256,
    parameter logic [7:0]      HALT_OPCODE = 8'hFF
) (
    input  logic                Clock,
    input  logic                Reset,
    instr_fetch_unit_if.master  bus
);
    // MEM_DEPTH is a power of two, so modulo reduces to a mask (all ones at 2^32).
    localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 64'd1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        handshake;
    logic        load_slot;
    logic        unused_mem_hi;

    assign handshake     = ir_valid_q & bus.ir_ready;
    assign load_slot     = ~ir_valid_q | bus.ir_ready;
    assign unused_mem_hi = ^bus.mem_q[31:8];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;

        if (handshake && fetch_count_q != 16'hFFFF)
            fetch_count_d = fetch_count_q + 16'd1;

        if (bus.br_taken) begin
            // Flush edge only; the target byte is fetched on the following edge.
            pc_d       = bus.br_target & PC_MASK;
            ir_valid_d = 1'b0;
            state_d    = RUN;
        end else if (state_q == RUN) begin
            if (load_slot) begin
                ir_d       = bus.mem_q[7:0];
                ir_pc_d    = pc_q;
                ir_valid_d = 1'b1;
                if (bus.mem_q[7:0] == HALT_OPCODE)
                    state_d = HALTED;
                else
                    pc_d = (pc_q + 32'd1) & PC_MASK;
            end
        end else begin
            if (handshake)
                ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC & PC_MASK;
            ir_q          <= 8'd0;
            ir_pc_q       <= 32'd0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.ir          = ir_q;
    assign bus.ir_pc       = ir_pc_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboard of expected (byte, pc) pairs checked on
// each delivered instruction, plus state checks around stall, redirect, halt and wrap.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic [7:0]  b;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t e;

    logic [7:0] mem_a [256];
    logic [7:0] mem_w [256];

    instr_fetch_unit_if bus_a ();
    instr_fetch_unit_if bus_w ();

    instr_fetch_unit #(.RESET_PC(32'd0), .MEM_DEPTH(256), .HALT_OPCODE(8'hFF)) dut (
        .Clock(clk), .Reset(rst), .bus(bus_a)
    );
    instr_fetch_unit #(.RESET_PC(32'hFE), .MEM_DEPTH(256), .HALT_OPCODE(8'hFF)) dut_w (
        .Clock(clk), .Reset(rst), .bus(bus_w)
    );

    assign bus_a.mem_q = {24'h0, mem_a[bus_a.mem_addr[7:0]]};
    assign bus_w.mem_q = {24'h0, mem_w[bus_w.mem_addr[7:0]]};

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_a.ir_ready = 1'b0;
        bus_a.br_taken = 1'b0;
        bus_a.br_target = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_a.mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr: got %0h expected 0", bus_a.mem_addr); end
        n_cmp++; if (bus_a.ir !== 8'd0) begin n_err++; $display("FAIL reset_ir: got %0h expected 0", bus_a.ir); end
        n_cmp++; if (bus_a.ir_pc !== 32'd0) begin n_err++; $display("FAIL reset_ir_pc: got %0h expected 0", bus_a.ir_pc); end
        n_cmp++; if (bus_a.ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid: got %b expected 0", bus_a.ir_valid); end
        n_cmp++; if (bus_a.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", bus_a.halted); end
        n_cmp++; if (bus_a.fetch_count !== 16'd0) begin n_err++; $display("FAIL reset_fetch_count: got %0d expected 0", bus_a.fetch_count); end
        n_cmp++; if (bus_w.mem_addr !== 32'hFE) begin n_err++; $display("FAIL reset_mem_addr_w: got %0h expected fe", bus_w.mem_addr); end
    endtask

    task automatic test_stream();
        apply_reset();
        exp_q.delete();
        exp_q.push_back('{8'hE7, 32'd0});
        exp_q.push_back('{8'hE9, 32'd1});
        exp_q.push_back('{8'hC1, 32'd2});
        exp_q.push_back('{8'hFF, 32'd3});
        @(negedge clk);
        n_cmp++; if (bus_a.ir_valid !== 1'b1) begin n_err++; $display("FAIL stream_first_valid: got %b expected 1", bus_a.ir_valid); end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            bus_a.ir_ready = 1'b1;
            if (bus_a.ir_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus_a.ir !== e.b || bus_a.ir_pc !== e.pc) begin
                    n_err++; $display("FAIL stream_ir: got %h/%0h expected %h/%0h", bus_a.ir, bus_a.ir_pc, e.b, e.pc);
                end
                if (e.b == 8'hFF) begin
                    n_cmp++; if (bus_a.halted !== 1'b1) begin n_err++; $display("FAIL stream_halted: got %b expected 1", bus_a.halted); end
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_timeout: %0d left expected 0", exp_q.size()); end
        n_cmp++; if (bus_a.ir_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_after: got %b expected 0", bus_a.ir_valid); end
        n_cmp++; if (bus_a.fetch_count !== 16'd4) begin n_err++; $display("FAIL stream_count: got %0d expected 4", bus_a.fetch_count); end
        n_cmp++; if (bus_a.mem_addr !== 32'd3) begin n_err++; $display("FAIL stream_mem_addr: got %0h expected 3", bus_a.mem_addr); end
    endtask

    // Continues from the HALTED state left by test_stream.
    task automatic test_halt_restart();
        repeat (10) @(negedge clk);
        n_cmp++; if (bus_a.halted !== 1'b1 || bus_a.mem_addr !== 32'd3 || bus_a.ir_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_persist: got halted=%b addr=%0h valid=%b expected 1/3/0", bus_a.halted, bus_a.mem_addr, bus_a.ir_valid);
        end
        bus_a.br_taken = 1'b1;
        bus_a.br_target = 32'h104;
        @(negedge clk);
        bus_a.br_taken = 1'b0;
        n_cmp++; if (bus_a.mem_addr !== 32'h4) begin n_err++; $display("FAIL restart_mem_addr: got %0h expected 4", bus_a.mem_addr); end
        n_cmp++; if (bus_a.halted !== 1'b0) begin n_err++; $display("FAIL restart_halted: got %b expected 0", bus_a.halted); end
        exp_q.push_back('{8'h5D, 32'd4});
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++; if (bus_a.ir_valid !== 1'b1 || bus_a.ir !== e.b || bus_a.ir_pc !== e.pc) begin
            n_err++; $display("FAIL restart_ir: got %b %h/%0h expected 1 %h/%0h", bus_a.ir_valid, bus_a.ir, bus_a.ir_pc, e.b, e.pc);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        exp_q.delete();
        exp_q.push_back('{8'hE7, 32'd0});
        exp_q.push_back('{8'hE9, 32'd1});
        exp_q.push_back('{8'hC1, 32'd2});
        exp_q.push_back('{8'hFF, 32'd3});
        @(negedge clk);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            bus_a.ir_ready = !(c >= 1 && c <= 3);
            if (!bus_a.ir_ready) begin
                n_cmp++;
                if (bus_a.ir !== 8'hE9 || bus_a.ir_pc !== 32'd1 || bus_a.ir_valid !== 1'b1 || bus_a.mem_addr !== 32'd2) begin
                    n_err++; $display("FAIL stall_hold: got %h/%0h v=%b addr=%0h expected e9/1 v=1 addr=2", bus_a.ir, bus_a.ir_pc, bus_a.ir_valid, bus_a.mem_addr);
                end
            end else if (bus_a.ir_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus_a.ir !== e.b || bus_a.ir_pc !== e.pc) begin
                    n_err++; $display("FAIL stall_ir: got %h/%0h expected %h/%0h", bus_a.ir, bus_a.ir_pc, e.b, e.pc);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_timeout: %0d left expected 0", exp_q.size()); end
        n_cmp++; if (bus_a.fetch_count !== 16'd4) begin n_err++; $display("FAIL stall_count: got %0d expected 4", bus_a.fetch_count); end
    endtask

    task automatic test_redirect_stall();
        apply_reset();
        @(negedge clk);
        bus_a.ir_ready = 1'b1;
        @(negedge clk);
        bus_a.ir_ready = 1'b0;
        n_cmp++; if (bus_a.ir !== 8'hE9 || bus_a.ir_valid !== 1'b1) begin n_err++; $display("FAIL redir_pre: got %h v=%b expected e9 v=1", bus_a.ir, bus_a.ir_valid); end
        bus_a.br_taken = 1'b1;
        bus_a.br_target = 32'h10;
        @(negedge clk);
        bus_a.br_taken = 1'b0;
        n_cmp++; if (bus_a.ir_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b expected 0", bus_a.ir_valid); end
        n_cmp++; if (bus_a.mem_addr !== 32'h10) begin n_err++; $display("FAIL redir_mem_addr: got %0h expected 10", bus_a.mem_addr); end
        exp_q.push_back('{8'h3C, 32'h10});
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++; if (bus_a.ir_valid !== 1'b1 || bus_a.ir !== e.b || bus_a.ir_pc !== e.pc) begin
            n_err++; $display("FAIL redir_target: got %b %h/%0h expected 1 %h/%0h", bus_a.ir_valid, bus_a.ir, bus_a.ir_pc, e.b, e.pc);
        end
        n_cmp++; if (bus_a.fetch_count !== 16'd1) begin n_err++; $display("FAIL redir_count: got %0d expected 1", bus_a.fetch_count); end
    endtask

    task automatic test_wrap();
        apply_reset();
        exp_q.delete();
        exp_q.push_back('{8'h7E, 32'hFE});
        exp_q.push_back('{8'h7F, 32'hFF});
        exp_q.push_back('{8'h00, 32'h00});
        exp_q.push_back('{8'h01, 32'h01});
        @(negedge clk);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (bus_w.ir_valid && bus_w.ir_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus_w.ir !== e.b || bus_w.ir_pc !== e.pc) begin
                    n_err++; $display("FAIL wrap_ir: got %h/%0h expected %h/%0h", bus_w.ir, bus_w.ir_pc, e.b, e.pc);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_timeout: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        bus_a.ir_ready = 1'b1;
        for (int c = 0; c < 20 && !(bus_a.halted && !bus_a.ir_valid); c++) @(negedge clk);
        bus_a.br_taken = 1'b1;
        bus_a.br_target = 32'h20;
        @(negedge clk);
        bus_a.br_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_a.ir_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_a.fetch_count !== 16'd5 || bus_a.halted !== 1'b1 || bus_a.ir_valid !== 1'b1 || bus_a.ir !== 8'hFF) begin
            n_err++; $display("FAIL midrst_pre: got cnt=%0d h=%b v=%b ir=%h expected 5/1/1/ff", bus_a.fetch_count, bus_a.halted, bus_a.ir_valid, bus_a.ir);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_a.mem_addr !== 32'd0 || bus_a.ir !== 8'd0 || bus_a.ir_pc !== 32'd0) begin
            n_err++; $display("FAIL midrst_regs: got addr=%0h ir=%h pc=%0h expected 0/00/0", bus_a.mem_addr, bus_a.ir, bus_a.ir_pc);
        end
        n_cmp++; if (bus_a.ir_valid !== 1'b0 || bus_a.halted !== 1'b0 || bus_a.fetch_count !== 16'd0) begin
            n_err++; $display("FAIL midrst_status: got v=%b h=%b cnt=%0d expected 0/0/0", bus_a.ir_valid, bus_a.halted, bus_a.fetch_count);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_a.ir_valid !== 1'b1 || bus_a.ir !== 8'hE7 || bus_a.ir_pc !== 32'd0) begin
            n_err++; $display("FAIL midrst_resume: got %b %h/%0h expected 1 e7/0", bus_a.ir_valid, bus_a.ir, bus_a.ir_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_w[i] = 8'(i & 8'h7F);
        end
        mem_a[0] = 8'hE7; mem_a[1] = 8'hE9; mem_a[2] = 8'hC1; mem_a[3] = 8'hFF;
        mem_a[4] = 8'h5D; mem_a[8'h10] = 8'h3C;
        mem_a[8'h20] = 8'h11; mem_a[8'h21] = 8'hFF;
        bus_a.ir_ready = 1'b0;
        bus_a.br_taken = 1'b0;
        bus_a.br_target = 32'd0;
        bus_w.ir_ready = 1'b1;
        bus_w.br_taken = 1'b0;
        bus_w.br_target = 32'd0;

        test_reset();
        test_stream();
        test_halt_restart();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that owns the program counter and drives the byte-wide instruction memory read port. Each cycle it presents the current PC as the memory address, captures the returned instruction byte into an instruction register, and offers it to the decode stage through a valid/ready handshake. Taken branches from downstream redirect the PC and flush the held instruction. A dedicated halt opcode stops fetching.

## Interface
- RESET_PC, 0: PC value loaded on reset.
- MEM_DEPTH, 256: instruction memory size in bytes; the PC wraps modulo this value. Must be a power of two, 2..2^32.
- HALT_OPCODE, 8'hFF: instruction byte that stops fetching.

- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- mem_addr  out  32  address to instruction memory; equals PC combinationally.
- mem_q  in  32  memory read data (combinational read); only [7:0] is used.
- ir  out  8  registered instruction byte.
- ir_pc  out  32  address the byte in `ir` was fetched from.
- ir_valid  out  1  `ir` / `ir_pc` hold an instruction not yet consumed.
- ir_ready  in  1  decode accepts `ir` this cycle when `ir_valid` is also high.
- br_taken  in  1  redirect request, sampled each rising edge.
- br_target  in  32  redirect address. It is reduced modulo MEM_DEPTH.
- halted  out  1  fetch is stopped (state HALTED).
- fetch_count  out  16  number of instructions delivered (accepted handshakes); saturates at 16'hFFFF.

## Operation
- The block has two states, RUN and HALTED.
- Definitions:
  - A handshake occurs on a cycle where `ir_valid && ir_ready`.
  - A load slot exists when `!ir_valid || ir_ready`.
- Priority at each rising edge, highest first:
  1. Reset:
     - PC is set to RESET_PC mod MEM_DEPTH.
     - `ir_valid` = 0.
     - `ir` = 0.
     - `ir_pc` = 0.
     - state = RUN.
     - `fetch_count` = 0.
  2. `br_taken`:
     - PC is set to `br_target` mod MEM_DEPTH.
     - `ir_valid` = 0, which flushes any held instruction even if stalled or offered this cycle.
     - state = RUN; this is the only exit from HALTED.
     - No fetch occurs this cycle.
     - `fetch_count` still increments if a handshake occurred this cycle.
  3. RUN with a load slot:
     - `ir` = mem_q[7:0].
     - `ir_pc` = PC.
     - `ir_valid` = 1.
     - If the fetched byte equals HALT_OPCODE, the halt byte is still delivered, PC holds, and state goes to HALTED.
     - Otherwise PC = (PC + 1) mod MEM_DEPTH.
  4. RUN without a load slot (stall): PC, `ir`, `ir_pc` and `ir_valid` all hold.
  5. HALTED: PC holds. A handshake clears `ir_valid`. No new fetch occurs.
- `fetch_count` increments on every handshake unless Reset is asserted; it saturates.
- `ir` and `ir_pc` keep stale values when `ir_valid` = 0. Decode must ignore them in that case.
- PC wrap: from MEM_DEPTH-1 the PC goes to 0 with no flag.

## Timing
- Reset values:
  - `mem_addr` = RESET_PC mod MEM_DEPTH.
  - `ir` = 0, `ir_pc` = 0, `ir_valid` = 0.
  - `halted` = 0.
  - `fetch_count` = 0.
- Latency:
  - The first `ir_valid` appears 1 cycle after Reset deasserts.
  - After a redirect, the target instruction is valid 2 edges after the edge that sampled `br_taken`: the flush edge, then the fetch edge.
- Throughput: one instruction per cycle while `ir_ready` is held high.
- Outputs are registered except `mem_addr`, which is a direct copy of the PC register.
- `halted` rises on the edge that loads HALT_OPCODE into `ir`.
- Reset asserted mid-stall or while HALTED behaves identically to a power-on reset.

## Test plan
- **Stream.** Mem[0..2] = E7, E9, C1, Mem[3] = FF, `ir_ready` = 1, Reset released.
  - `ir` sequence is E7/0, E9/1, C1/2, FF/3 on consecutive cycles (byte/`ir_pc`).
  - `halted` = 1 with FF.
  - `ir_valid` = 0 the cycle after.
  - `fetch_count` = 4.
  - `mem_addr` stays at 3.
- **Stall.** Same program, `ir_ready` low on cycles 2–4.
  - `ir` = E9, `ir_pc` = 1 held with `ir_valid` = 1.
  - `mem_addr` = 2 held.
  - On release, C1 follows next cycle.
  - No byte is lost or duplicated.
- **Redirect under stall.** `br_taken` = 1 with `br_target` = 0x10 while E9 is held and `ir_ready` = 0.
  - Next cycle `ir_valid` = 0 and `mem_addr` = 0x10.
  - The following cycle presents Mem[0x10] with `ir_pc` = 0x10.
  - `fetch_count` is unchanged.
- **Restart from halt.**
  - While HALTED, assert `br_taken` with `br_target` = 0x104 (MEM_DEPTH = 256): `mem_addr` = 0x04, state = RUN, and Mem[4] is delivered.
  - Without `br_taken`, HALTED persists indefinitely.
- **Wrap.** Start at RESET_PC = 0xFE with no halt bytes: the `ir_pc` sequence is FE, FF, 00, 01.
- **Reset mid-operation.** Assert Reset while `ir_valid` = 1, `fetch_count` = 5 and HALTED.
  - Next edge: all outputs at their reset values and `halted` = 0.
  - Fetch resumes from RESET_PC after Reset drops.
